// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the RV32M multiply/divide sequencer.
//   - Datapath width and iteration count (ITER must equal XLEN: one result
//     bit is produced per iteration).
//   - funct3-style op encodings MD_MUL..MD_REMU.
//   - Sequencer state encodings S_IDLE/S_CALC/S_FIX/S_DONE.
//   - Small decode helpers so the controller reads in terms of op classes.
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    typedef logic [2:0] md_op_t;
    typedef logic [1:0] md_state_t;

    // Op encodings (match RV32M funct3).
    localparam md_op_t MD_MUL    = 3'd0;
    localparam md_op_t MD_MULH   = 3'd1;
    localparam md_op_t MD_MULHSU = 3'd2;
    localparam md_op_t MD_MULHU  = 3'd3;
    localparam md_op_t MD_DIV    = 3'd4;
    localparam md_op_t MD_DIVU   = 3'd5;
    localparam md_op_t MD_REM    = 3'd6;
    localparam md_op_t MD_REMU   = 3'd7;

    // Sequencer states.
    localparam md_state_t S_IDLE = 2'd0;
    localparam md_state_t S_CALC = 2'd1;
    localparam md_state_t S_FIX  = 2'd2;
    localparam md_state_t S_DONE = 2'd3;

    // DIV/DIVU/REM/REMU all have bit 2 set.
    function automatic logic op_is_div(input md_op_t op);
        return op[2];
    endfunction

    // REM/REMU: bits 2 and 1 set.
    function automatic logic op_is_rem(input md_op_t op);
        return op[2] & op[1];
    endfunction

    // Operand A is treated as signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic op_a_signed(input md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Operand B is treated as signed for MUL, MULH, DIV, REM (not MULHSU).
    function automatic logic op_b_signed(input md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // MULH/MULHSU/MULHU return the upper half of the product.
    function automatic logic op_hi_word(input md_op_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

endpackage

// File: rtl/md_iter_dp.sv
// -----------------------------------------------------------------------------
// md_iter_dp
// Iteration datapath shared by multiply and divide. Works on unsigned
// magnitudes only; sign handling lives in the controller.
//
// Register roles:
//   multiply : {hi,lo} is the double-width product register. lo starts as the
//              multiplier; each step conditionally adds the multiplicand (b)
//              into hi and shifts {carry,hi,lo} right by one.
//   divide   : hi is the partial remainder, lo starts as the dividend and
//              fills with quotient bits. Each step shifts {hi,lo} left, does
//              a trial subtract of the divisor (b) and keeps the old value
//              when the subtraction would go negative (restoring divide).
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load_i      capture operands and mode, clear hi
//   step_i      perform one iteration
//   div_mode_i  mode captured on load: 1 = divide, 0 = multiply
//   a_i, b_i    operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   hi_o, lo_o  product high/low, or remainder/quotient
// -----------------------------------------------------------------------------
module md_iter_dp
    import md_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] b_q,  b_d;
    logic         div_q, div_d;

    logic [W:0]   mul_sum;    // hi + (lo[0] ? b : 0), with carry
    logic [W:0]   div_shift;  // partial remainder after the left shift
    logic         div_fits;   // trial subtract is non-negative
    logic [W-1:0] div_sub;    // trial difference; fits W bits when div_fits

    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned and no latch is inferred.
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;

        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_fits  = (div_shift >= {1'b0, b_q});
        // Remainder after a successful subtract is < b, so modular W-bit
        // subtraction of the low bits gives the exact value.
        div_sub   = div_shift[W-1:0] - b_q;

        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            b_d   = b_i;
            div_d = div_mode_i;
        end else if (step_i) begin
            if (div_q) begin
                if (div_fits) begin
                    hi_d = div_sub;
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    // Restore: keep the shifted remainder, quotient bit 0.
                    hi_d = div_shift[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[W:1];
                lo_d = {mul_sum[0], lo_q[W-1:1]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// md_seq_ctrl
// Multi-cycle RV32M multiply/divide sequencer for the EX stage. Holds the
// pipeline while a radix-2 shift-add multiply or restoring divide iterates,
// then presents the result with a one-cycle done pulse.
//
// Timing for an op accepted at the edge ending cycle T:
//   normal op    : CALC T+1..T+32, FIX T+33, DONE (done_out) T+34
//   special case : DONE (done_out) T+1
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   valid_in    M-op present in EX; held by the pipeline while stall_out=1
//   md_op_in    op select (MD_MUL..MD_REMU)
//   rs1_in      operand A, sampled on accept only
//   rs2_in      operand B, sampled on accept only
//   flush_in    abandon the in-flight op
//   stall_out   freeze PC/IF/ID/EX
//   busy_out    sequencer not idle
//   done_out    one-cycle pulse, result_out valid
//   result_out  last result, held until the next done
// -----------------------------------------------------------------------------
module md_seq_ctrl
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      md_op_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_t        state_q,  state_d;
    md_op_t           op_q,     op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [XLEN-1:0]  result_q, result_d;

    // ------------------------------------------------------------------
    // Accept-time decode: operand signs, magnitudes, special cases
    // ------------------------------------------------------------------
    logic            accept;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] abs_a_in, abs_b_in;
    logic            div_by_zero, div_overflow, special;
    logic [XLEN-1:0] special_res;

    assign accept   = (state_q == S_IDLE) && valid_in && !flush_in;

    // Sign is only meaningful for operands the op treats as signed; an
    // unsigned operand always records sign 0 so FIX needs no op checks.
    assign neg_a_in = op_a_signed(md_op_in) & rs1_in[XLEN-1];
    assign neg_b_in = op_b_signed(md_op_in) & rs2_in[XLEN-1];
    // INT_MIN negates to itself, which is its correct unsigned magnitude.
    assign abs_a_in = neg_a_in ? (-rs1_in) : rs1_in;
    assign abs_b_in = neg_b_in ? (-rs2_in) : rs2_in;

    assign div_by_zero  = op_is_div(md_op_in) && (rs2_in == '0);
    // Only signed DIV/REM can overflow (INT_MIN / -1).
    assign div_overflow = op_is_div(md_op_in) && op_a_signed(md_op_in) &&
                          (rs1_in == INT_MIN) && (rs2_in == '1);
    assign special      = div_by_zero || div_overflow;

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = op_is_rem(md_op_in) ? rs1_in : '1;
        end else if (div_overflow) begin
            special_res = op_is_rem(md_op_in) ? '0 : INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic            dp_load, dp_step;
    logic [XLEN-1:0] dp_hi, dp_lo;

    assign dp_load = accept && !special;
    assign dp_step = (state_q == S_CALC) && !flush_in;

    md_iter_dp #(
        .W (XLEN)
    ) u_iter_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dp_load),
        .step_i     (dp_step),
        .div_mode_i (op_is_div(md_op_in)),
        .a_i        (abs_a_in),
        .b_i        (abs_b_in),
        .hi_o       (dp_hi),
        .lo_o       (dp_lo)
    );

    // ------------------------------------------------------------------
    // Sign correction and result selection (FIX state)
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    assign prod_mag = {dp_hi, dp_lo};
    // MULHSU records sign_b = 0, so sign_a ^ sign_b reduces to sign_a.
    assign prod_fix = (sign_a_q ^ sign_b_q) ? (-prod_mag) : prod_mag;
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? (-dp_lo) : dp_lo;
    // Remainder follows the dividend's sign.
    assign rem_fix  = sign_a_q ? (-dp_hi) : dp_hi;

    always_comb begin
        if (op_is_div(op_q)) begin
            fix_res = op_is_rem(op_q) ? rem_fix : quo_fix;
        end else begin
            fix_res = op_hi_word(op_q) ? prod_fix[2*XLEN-1:XLEN]
                                       : prod_fix[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = md_op_in;
                    sign_a_d = neg_a_in;
                    sign_b_d = neg_b_in;
                    count_d  = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // count holds at CNT_LAST on exit rather than wrapping.
                if (count_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                // valid_in is ignored here: the same instruction is still in
                // EX this cycle and must not be accepted a second time.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush abandons whatever is in flight and leaves result_out
        // untouched. In DONE the pulse is already registered and still shows.
        if (flush_in) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= MD_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall drops in DONE so the pipeline advances exactly when the result
    // is on result_out.
    assign stall_out  = valid_in && (state_q != S_DONE);
    assign busy_out   = (state_q != S_IDLE);
    assign done_out   = (state_q == S_DONE);
    assign result_out = result_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_seq_ctrl
// Directed bench for md_seq_ctrl. Stimulus pushes the expected result and the
// cycle in which done_out must appear; a monitor pops and compares on every
// done_out pulse. Inputs change 1 time unit after posedge, outputs are read
// on negedge.
// -----------------------------------------------------------------------------
module tb_md_seq_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  md_op_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic        flush_in;
    logic        stall_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] result_out;

    md_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .md_op_in   (md_op_in),
        .rs1_in     (rs1_in),
        .rs2_in     (rs2_in),
        .flush_in   (flush_in),
        .stall_out  (stall_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    // Cycle k is the period that starts at the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          done_seen = 0;
    logic [31:0] last_res  = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done_out pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_out === 1'b1) begin
                done_seen++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done_out in cycle %0d with result 0x%08h, none expected",
                             cyc, result_out);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, result_out, e.res);
                    check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Present one op and hold valid_in until done_out is seen. stall_out must
    // be 1 every cycle up to done and 0 in the done cycle.
    task automatic issue(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int t;
        bit seen;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        md_op_in = op;
        rs1_in   = a;
        rs2_in   = b;
        t        = cyc;
        sb_q.push_back('{exp, t + lat, name});
        last_res = exp;
        seen     = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done_out === 1'b1) begin
                seen = 1'b1;
                check({name, "_stall_at_done"}, 32'(stall_out), 32'd0);
            end else begin
                check({name, "_stall_busy"}, 32'(stall_out), 32'd1);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done_out within 60 cycles of cycle %0d", name, t);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Start a DIV 100/7 and abort it in cycle T+10 with flush or reset.
    task automatic abort_div(input bit use_rst, input logic [31:0] exp_res);
        int t;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        md_op_in = MD_DIVU;
        rs1_in   = 32'd100;
        rs2_in   = 32'd7;
        t        = cyc;
        while (cyc < t + 10) begin
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (use_rst) rst = 1'b1;
        else         flush_in = 1'b1;
        @(negedge clk);
        check(use_rst ? "rst_busy_before" : "flush_busy_before", 32'(busy_out), 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        flush_in = 1'b0;
        @(negedge clk);
        check(use_rst ? "rst_busy_after"   : "flush_busy_after",   32'(busy_out),  32'd0);
        check(use_rst ? "rst_done_after"   : "flush_done_after",   32'(done_out),  32'd0);
        check(use_rst ? "rst_result_after" : "flush_result_after", result_out,     exp_res);
        check(use_rst ? "rst_stall_after"  : "flush_stall_after",  32'(stall_out), 32'd0);
        // Idle long enough that a surviving op would have raised done_out.
        repeat (40) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        rst      = 1'b1;
        valid_in = 1'b0;
        flush_in = 1'b0;
        md_op_in = '0;
        rs1_in   = '0;
        rs2_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   32'(busy_out),  32'd0);
        check("reset_done",   32'(done_out),  32'd0);
        check("reset_result", result_out,     32'd0);
        check("reset_stall",  32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Iterative ops: done in T+34.
        issue("mul_7_m3",      MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34); idle();
        issue("mulh_min_min",  MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34); idle();
        issue("mulhu_max_max", MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34); idle();
        issue("mulhsu_m1_2",   MD_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34); idle();
        issue("div_m7_2",      MD_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34); idle();
        issue("rem_m7_2",      MD_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34); idle();
        issue("divu_100_7",    MD_DIVU,   32'd100,      32'd7,        32'd14,        34); idle();
        issue("remu_100_7",    MD_REMU,   32'd100,      32'd7,        32'd2,         34); idle();

        // Special cases: done in T+1.
        issue("divu_by0",      MD_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1); idle();
        issue("rem_by0",       MD_REM,    32'd5,        32'd0,        32'd5,         1); idle();
        issue("div_ovf",       MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); idle();
        issue("rem_ovf",       MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1); idle();

        // Flush mid-op keeps the previous result, then a normal op follows.
        abort_div(1'b0, last_res);
        issue("mul_3_4",       MD_MUL,    32'd3,        32'd4,        32'd12,        34); idle();

        // Reset mid-op clears everything.
        abort_div(1'b1, 32'd0);
        last_res = '0;

        // Back-to-back with valid_in held across both ops.
        d0 = done_seen;
        issue("b2b_mul_2_3",   MD_MUL,    32'd2,        32'd3,        32'd6,         34);
        issue("b2b_mul_5_5",   MD_MUL,    32'd5,        32'd5,        32'd25,        34);
        idle();
        repeat (40) @(posedge clk);
        check("b2b_done_count", 32'(done_seen - d0), 32'd2);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
Multi-cycle sequencer for RV32M multiply/divide operations in the EX stage, alongside the single-cycle ALU.
- Accepts an M-extension op from decode and holds the pipeline (stall_out) while it iterates.
- Runs a radix-2 shift-add (MUL*) or restoring-divide (DIV*/REM*) loop, then presents a 1-cycle done_out with the result.
- The EX result mux selects result_out over the ALU result when done_out is high.

Parameters:
XLEN, 32, operand/result width
ITER, 32, iterations per op (must equal XLEN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
valid_in  in  1  M-op present in EX; held high by the pipeline while stall_out=1
md_op_in  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_in  in  XLEN  operand A, sampled only on accept
rs2_in  in  XLEN  operand B, sampled only on accept
flush_in  in  1  kill the in-flight op (branch mispredict/trap)
stall_out  out  1  freeze PC/IF/ID/EX registers
busy_out  out  1  state != IDLE
done_out  out  1  1-cycle pulse; result_out valid
result_out  out  XLEN  final result; holds until next done

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; done_out=0, busy_out=0, result_out=0; all internal registers cleared. rst overrides flush_in and valid_in. Reset mid-operation abandons the op with no done_out.
- States: IDLE, CALC, FIX, DONE.
- IDLE, valid_in=1, flush_in=0 → accept:
  - Latch op and operands; record the sign of each operand (signed ops only); take absolute values into the iteration registers.
  - Special cases, bypassing CALC and going directly to DONE:
    - DIV/DIVU with rs2=0 → quotient 0xFFFFFFFF.
    - REM/REMU with rs2=0 → remainder = rs1.
    - Signed DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All other ops → CALC with count=0.
- CALC: one iteration per cycle; count increments; after ITER iterations (count==ITER-1) → FIX.
  - MUL*: 64-bit product register, add-and-shift on the multiplier LSB.
  - DIV*: {rem, quo} shifted left, trial subtract, restore on a negative result.
- FIX (1 cycle) applies sign correction, then → DONE:
  - MUL/MULH: product negated if sign_a ^ sign_b.
  - MULHSU: negated if sign_a only.
  - DIV: quotient negated if sign_a ^ sign_b.
  - REM: remainder takes the sign of the dividend.
  - Result selection: MUL → low word; MULH/MULHSU/MULHU → high word.
- DONE: done_out=1, result_out updated on entry; → IDLE next cycle. valid_in is ignored in DONE, so the same instruction is never re-accepted.
- Latency, accept at edge T:
  - Normal op: CALC T+1..T+32, FIX T+33, done_out high in cycle T+34.
  - Special case: done_out high in cycle T+1.
- stall_out = valid_in & (state != DONE), combinational. It is high in the accept cycle. It is low in the DONE cycle so the pipeline advances exactly when the result is valid.
- flush_in=1 in any non-reset cycle → IDLE next edge. No done_out, result_out unchanged. Flush in IDLE with valid_in=1 suppresses the accept. Flush in DONE: done_out still pulses that cycle, state → IDLE.
- A new op may be accepted in the cycle directly after DONE (IDLE), giving back-to-back ops with no bubble beyond that IDLE cycle.
- count is 5 bits and never wraps: it is cleared on accept and saturates at exit.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MUL..MD_REMU
  - state encodings S_IDLE/S_CALC/S_FIX/S_DONE
  - localparams XLEN=32, ITER=32, CNT_W=5
- One sub-module, md_iter_dp: the iteration datapath (product/remainder/quotient registers, one step per enable, mode = mul/div).
- md_seq_ctrl holds the FSM, operand sign capture, special-case detection, sign fix and stall/done logic.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), valid_in held → stall_out=1 for cycles T..T+33; done_out=1 only at T+34; result 0xFFFFFFEB; stall_out=0 at T+34.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with done_out at T+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Flush and reset mid-op:
  - flush_in pulsed at T+10 of a DIV → busy_out=0 at T+11, no done_out, result_out keeps its previous value.
  - A following MUL 3×4 is accepted and returns 12 at its own T+34.
  - Repeat the DIV with rst at T+10 → all outputs 0.
- Back-to-back: two MULs with valid_in held continuously (2×3 then 5×5) → exactly two done_out pulses, results 6 then 25, second accept in the IDLE cycle right after the first DONE.
